// File: rtl/fifo2axi_unpack.sv
// fifo2axi_unpack: rebuilds 256-bit AXI-Stream beats from a FWFT FIFO of
// 202-bit stored words (24-byte payload + control). Four data words (kinds
// 1..4) carry three beats; a kind-0 header word supplies the packet tuser.
//
// Ports
//   clk, reset      single clock, synchronous active-high reset
//   din             stored word {payload[201:10], cnt[9:5], kind[4:2], last[1], unused[0]}
//   din_valid       FWFT word present
//   din_rd_en       pop strobe (combinational)
//   m_tdata/m_tstrb/m_tuser/m_tlast/m_tvalid/m_tready   AXI-Stream master
//   proto_err       one-cycle pulse when a word of the wrong kind is dropped
//   pkt_count       packets emitted (handshakes with m_tlast), wraps
module fifo2axi_unpack #(
   parameter int unsigned TDATA_WIDTH        = 32,
   parameter int unsigned TUSER_WIDTH        = 16,
   parameter int unsigned CROPPED_DATA_WIDTH = 24
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [CROPPED_DATA_WIDTH*8+9:0] din,
   input  logic                            din_valid,
   output logic                            din_rd_en,
   output logic [TDATA_WIDTH*8-1:0]        m_tdata,
   output logic [TDATA_WIDTH-1:0]          m_tstrb,
   output logic [TUSER_WIDTH*8-1:0]        m_tuser,
   output logic                            m_tlast,
   output logic                            m_tvalid,
   input  logic                            m_tready,
   output logic                            proto_err,
   output logic [15:0]                     pkt_count
);

   localparam int unsigned DW = TDATA_WIDTH * 8;
   localparam int unsigned UW = TUSER_WIDTH * 8;
   localparam int unsigned PW = CROPPED_DATA_WIDTH * 8;

   typedef enum logic [2:0] {
      HDR = 3'd0,
      D1  = 3'd1,
      D2  = 3'd2,
      D3  = 3'd3,
      D4  = 3'd4
   } state_t;

   // Strobe for a final beat holding c bytes; c == 0 means a full beat.
   function automatic logic [TDATA_WIDTH-1:0] strb_of(input logic [4:0] c);
      logic [TDATA_WIDTH-1:0] s;
      for (int i = 0; i < int'(TDATA_WIDTH); i++) begin
         s[i] = (c == 5'd0) || (5'(i) < c);
      end
      return s;
   endfunction

   // Zero every data byte whose strobe bit is clear.
   function automatic logic [DW-1:0] mask_bytes(input logic [DW-1:0] d,
                                                input logic [TDATA_WIDTH-1:0] s);
      logic [DW-1:0] r;
      for (int i = 0; i < int'(TDATA_WIDTH); i++) begin
         r[8*i +: 8] = d[8*i +: 8] & {8{s[i]}};
      end
      return r;
   endfunction

   // Word fields
   logic [PW-1:0] pay;
   logic [4:0]    cnt;
   logic [2:0]    kind;
   logic          last;
   logic          unused_bit;

   assign pay        = din[PW+9:10];
   assign cnt        = din[9:5];
   assign kind       = din[4:2];
   assign last       = din[1];
   assign unused_bit = din[0];

   state_t                 state_q, state_d;
   logic [PW-1:0]          res_q, res_d;
   logic [UW-1:0]          tuser_q, tuser_d;
   logic                   tail_q, tail_d;
   logic [DW-1:0]          tail_data_q, tail_data_d;
   logic [TDATA_WIDTH-1:0] tail_strb_q, tail_strb_d;

   logic [DW-1:0]          tdata_d;
   logic [TDATA_WIDTH-1:0] tstrb_d;
   logic [UW-1:0]          tuser_out_d;
   logic                   tlast_d, tvalid_d, err_d;

   logic                   ld, ld_last;
   logic [DW-1:0]          ld_data;
   logic [TDATA_WIDTH-1:0] ld_strb, fin_strb;
   logic [2:0]             exp_kind;
   logic                   out_free, pop;

   // A word may be popped only when the output register can take a beat.
   assign out_free  = !m_tvalid || m_tready;
   assign din_rd_en = din_valid && out_free && !reset;
   assign pop       = din_rd_en;
   assign fin_strb  = strb_of(cnt);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= HDR;
      else       state_q <= state_d;
   end

   // Next state, residue/tuser update and output-register next values
   always_comb begin
      state_d     = state_q;
      res_d       = res_q;
      tuser_d     = tuser_q;
      tail_d      = tail_q;
      tail_data_d = tail_data_q;
      tail_strb_d = tail_strb_q;
      err_d       = 1'b0;
      ld          = 1'b0;
      ld_last     = 1'b0;
      ld_data     = '0;
      ld_strb     = '1;
      tvalid_d    = m_tvalid;
      tdata_d     = m_tdata;
      tstrb_d     = m_tstrb;
      tuser_out_d = m_tuser;
      tlast_d     = m_tlast;

      case (state_q)
         D1:      exp_kind = 3'd1;
         D2:      exp_kind = 3'd2;
         D3:      exp_kind = 3'd3;
         D4:      exp_kind = 3'd4;
         default: exp_kind = 3'd0;
      endcase

      if (pop) begin
         if (kind != exp_kind) begin
            // Drop the word and any partial beat; a header restarts a packet.
            err_d = 1'b1;
            res_d = '0;
            if (kind == 3'd0) begin
               tuser_d = pay[UW-1:0];
               state_d = D1;
            end else begin
               state_d = HDR;
            end
         end else begin
            case (state_q)
               HDR: begin
                  tuser_d = pay[UW-1:0];
                  res_d   = '0;
                  state_d = D1;
               end
               D1: begin
                  if (last) begin
                     ld      = 1'b1;
                     ld_last = 1'b1;
                     ld_strb = fin_strb;
                     ld_data = mask_bytes({64'b0, pay}, fin_strb);
                     res_d   = '0;
                     state_d = HDR;
                  end else begin
                     res_d   = pay;
                     state_d = D2;
                  end
               end
               D2: begin
                  ld      = 1'b1;
                  ld_data = {pay[63:0], res_q};
                  if (last) begin
                     res_d   = '0;
                     state_d = HDR;
                     if (cnt == 5'd0 || cnt >= 5'd25) begin
                        ld_last = 1'b1;
                        ld_strb = fin_strb;
                        ld_data = mask_bytes({pay[63:0], res_q}, fin_strb);
                     end else begin
                        // B0 goes out full now; B1 follows from the tail register.
                        tail_d      = 1'b1;
                        tail_strb_d = fin_strb;
                        tail_data_d = mask_bytes({128'b0, pay[191:64]}, fin_strb);
                     end
                  end else begin
                     res_d   = pay;
                     state_d = D3;
                  end
               end
               D3: begin
                  ld      = 1'b1;
                  ld_data = {pay[127:0], res_q[191:64]};
                  if (last) begin
                     res_d   = '0;
                     state_d = HDR;
                     if (cnt == 5'd0 || cnt >= 5'd17) begin
                        ld_last = 1'b1;
                        ld_strb = fin_strb;
                        ld_data = mask_bytes({pay[127:0], res_q[191:64]}, fin_strb);
                     end else begin
                        tail_d      = 1'b1;
                        tail_strb_d = fin_strb;
                        tail_data_d = mask_bytes({192'b0, pay[191:128]}, fin_strb);
                     end
                  end else begin
                     res_d   = pay;
                     state_d = D4;
                  end
               end
               D4: begin
                  ld      = 1'b1;
                  ld_data = {pay, res_q[191:128]};
                  if (last) begin
                     ld_last = 1'b1;
                     ld_strb = fin_strb;
                     ld_data = mask_bytes({pay, res_q[191:128]}, fin_strb);
                     res_d   = '0;
                     state_d = HDR;
                  end else begin
                     state_d = D1;
                  end
               end
               default: state_d = HDR;
            endcase
         end
      end

      // A pending tail only exists in HDR, where popped words never emit a
      // beat, so the tail and a word-driven load never compete.
      if (tail_q && out_free) begin
         tail_d      = 1'b0;
         tvalid_d    = 1'b1;
         tdata_d     = tail_data_q;
         tstrb_d     = tail_strb_q;
         tlast_d     = 1'b1;
         tuser_out_d = tuser_q;
      end else if (ld) begin
         tvalid_d    = 1'b1;
         tdata_d     = ld_data;
         tstrb_d     = ld_strb;
         tlast_d     = ld_last;
         tuser_out_d = tuser_q;
      end else if (m_tvalid && m_tready) begin
         tvalid_d = 1'b0;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         res_q       <= '0;
         tuser_q     <= '0;
         tail_q      <= 1'b0;
         tail_data_q <= '0;
         tail_strb_q <= '0;
         m_tvalid    <= 1'b0;
         m_tdata     <= '0;
         m_tstrb     <= '0;
         m_tuser     <= '0;
         m_tlast     <= 1'b0;
         proto_err   <= 1'b0;
         pkt_count   <= '0;
      end else begin
         res_q       <= res_d;
         tuser_q     <= tuser_d;
         tail_q      <= tail_d;
         tail_data_q <= tail_data_d;
         tail_strb_q <= tail_strb_d;
         m_tvalid    <= tvalid_d;
         m_tdata     <= tdata_d;
         m_tstrb     <= tstrb_d;
         m_tuser     <= tuser_out_d;
         m_tlast     <= tlast_d;
         proto_err   <= err_d;
         if (m_tvalid && m_tready && m_tlast) pkt_count <= pkt_count + 16'd1;
      end
   end

endmodule
